mp_add_sequencer: RTL and testbench
===================================

# mp_add_sequencer

Multi-precision add/subtract sequencer that shares one WIDTH-bit carry-lookahead adder across WORDS word slices. It performs a WORDS*WIDTH-bit addition one word per cycle and chains the carry between slices in a register. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides. It is used where a full-width adder would cost too much area.

## Interface
- WIDTH, 32: width of one slice, and of the single carryLookAheadAdder instance.
- WORDS, 4: number of slices. Must be ≥1. Total operand width is WIDTH*WORDS.
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand bundle valid.
- in_ready  output  1  sequencer can accept an operand bundle.
- a  input  WIDTH*WORDS  operand A. Word 0 is the least-significant slice.
- b  input  WIDTH*WORDS  operand B.
- cin  input  1  carry-in to word 0.
- sub  input  1  subtract request. Only active with MP_ADD_SUB_EN.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH*WORDS  registered result.
- cout  output  1  carry out of the top slice.
- overflow  output  1  signed overflow of the full-width result.

## Operation
- One clock domain. rst_n is asynchronous and active-low.
- States:
  - IDLE: in_ready=1.
  - RUN: slice counter idx runs 0..WORDS-1.
  - DONE: out_valid=1.
- IDLE→RUN on in_valid&&in_ready.
  - a and b are captured into internal registers; later input changes have no effect.
  - The carry register is loaded with the effective carry-in.
  - idx is cleared to 0.
- RUN, each cycle:
  - The adder computes slice idx from the captured operands and the carry register.
  - sum word idx is written and the carry register takes the slice carry-out.
  - idx is incremented.
- RUN→DONE after the slice WORDS-1 is written. On that cycle:
  - cout is registered from the slice carry-out.
  - overflow is registered from the slice overflow (c[W]^c[W-1] of the top slice).
- DONE→IDLE on out_ready.
- in_valid is ignored in RUN and DONE. There is no overlap of operations.
- Result registers hold their values until the next accept. They are not cleared on handoff.
- Arithmetic:
  - Add: sum = (a+b+cin) mod 2^(WIDTH*WORDS).
  - Subtract (sub=1, macro enabled):
    - The adder sees ~b, and the effective carry-in is 1; cin is ignored.
    - sum = a−b.
    - cout=1 means no borrow, i.e. a≥b unsigned.
  - overflow is two's-complement overflow of the full-width operation.
- WORDS=1: RUN lasts one cycle.

## Timing
- Reset values:
  - State is IDLE and idx=0.
  - in_ready=1.
  - out_valid=0.
  - sum=0, cout=0, overflow=0.
  - Carry register is 0.
- Latency: accept at edge T gives out_valid=1 after edge T+WORDS.
- Throughput: one operation per WORDS+2 cycles minimum, including the accept and handoff edges.
- in_ready and out_valid are decoded from state only, with no combinational path from inputs.
- Backpressure in DONE:
  - While out_ready=0, out_valid stays 1 and sum, cout and overflow are stable.
  - in_ready stays 0.
- If out_ready is already high when DONE is entered, handoff occurs on the next edge and in_ready=1 the cycle after.
- rst_n asserted in any state, including mid-RUN:
  - All outputs go to reset values immediately.
  - The partial result is discarded.
  - The operation is not resumed.

## Configuration
- MP_ADD_SUB_EN defined:
  - The sub port is honoured: ~b is fed to the adder, and the effective carry-in is 1.
  - sub is captured at accept.
- MP_ADD_SUB_EN undefined:
  - The sub port is still present but ignored; the sequencer always adds with cin.
  - No inverter logic is synthesized.

## Test plan
All scenarios use WIDTH=8, WORDS=4.
- Add with carry between slices: a=0x000000FF, b=0x00000001, cin=0 → sum=0x00000100, cout=0, overflow=0; out_valid rises 4 edges after accept.
- Full wrap: a=0xFFFFFFFF, b=0x00000001, cin=0 → sum=0x00000000, cout=1, overflow=0. With cin=1 and b=0 → same result.
- Signed overflow: a=0x7FFFFFFF, b=0x00000001 → sum=0x80000000, cout=0, overflow=1.
- Subtract (MP_ADD_SUB_EN defined): a=5, b=7, sub=1, cin=0 → sum=0xFFFFFFFE, cout=0, overflow=0. a=7, b=5 → sum=2, cout=1.
- Backpressure and no overlap:
  - Hold out_ready=0 for 3 cycles in DONE → outputs stable, in_ready=0.
  - in_valid pulsed during RUN → ignored.
  - Second op accepted only after the handoff edge.
- Reset mid-RUN: assert rst_n=0 after 2 RUN cycles → out_valid=0, in_ready=1, sum=0 without a clock edge. The next op completes correctly.

Source files
------------

// File: rtl/mp_add_sequencer_if.sv
// rtl/mp_add_sequencer_if.sv - operand/result handshake bundle for mp_add_sequencer
//
// Groups the producer-side (in_valid/in_ready, a, b, cin, sub) and the
// consumer-side (out_valid/out_ready, sum, cout, overflow) signals.
//   master : producer/consumer side (drives operands and out_ready)
//   slave  : sequencer side (drives in_ready and the result)
interface mp_add_sequencer_if #(
  parameter int WIDTH = 32,
  parameter int WORDS = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic [WIDTH*WORDS-1:0]   a;
  logic [WIDTH*WORDS-1:0]   b;
  logic                     cin;
  logic                     sub;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH*WORDS-1:0]   sum;
  logic                     cout;
  logic                     overflow;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, overflow
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, overflow
  );
endinterface

// File: rtl/mp_add_sequencer.sv
// rtl/mp_add_sequencer.sv - multi-precision add/subtract over one shared WIDTH-bit adder
//
// Adds two WIDTH*WORDS-bit operands one WIDTH-bit slice per cycle, chaining
// the slice carry through a register. Optional subtract support is built
// only when MP_ADD_SUB_EN is defined; otherwise the sub input is ignored.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : mp_add_sequencer_if.slave (operand in, result out handshakes)

// Single-slice adder with flattened carry lookahead: every carry is formed
// directly from the generate/propagate terms rather than from the previous carry.
module carry_lookahead_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             overflow_o
);
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   c;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  always_comb begin
    logic gp;
    logic pp;
    c    = '0;
    c[0] = cin_i;
    for (int i = 0; i < WIDTH; i++) begin
      gp = 1'b0;
      pp = 1'b1;
      for (int j = i; j >= 0; j--) begin
        gp = gp | (pp & g[j]);
        pp = pp & p[j];
      end
      c[i+1] = gp | (pp & cin_i);
    end
  end

  assign sum_o      = p ^ c[WIDTH-1:0];
  assign cout_o     = c[WIDTH];
  assign overflow_o = c[WIDTH] ^ c[WIDTH-1];
endmodule

module mp_add_sequencer #(
  parameter int WIDTH = 32,
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  mp_add_sequencer_if.slave  bus
);
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int TOT   = WIDTH * WORDS;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [TOT-1:0]     a_q, a_d;
  logic [TOT-1:0]     b_q, b_d;
  logic               carry_q, carry_d;
  logic [TOT-1:0]     sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic [WIDTH-1:0]   slice_a;
  logic [WIDTH-1:0]   slice_b;
  logic [WIDTH-1:0]   slice_sum;
  logic               slice_cout;
  logic               slice_ovf;
  logic               cin_eff;

  assign slice_a = a_q[int'(idx_q)*WIDTH +: WIDTH];

`ifdef MP_ADD_SUB_EN
  logic sub_q, sub_d;
  // Subtract is a + ~b + 1; cin is not used in that mode.
  assign slice_b = sub_q ? ~b_q[int'(idx_q)*WIDTH +: WIDTH] : b_q[int'(idx_q)*WIDTH +: WIDTH];
  assign cin_eff = bus.sub ? 1'b1 : bus.cin;
`else
  logic unused_sub;
  assign unused_sub = bus.sub;
  assign slice_b    = b_q[int'(idx_q)*WIDTH +: WIDTH];
  assign cin_eff    = bus.cin;
`endif

  carry_lookahead_adder #(.WIDTH(WIDTH)) u_cla (
    .a_i        (slice_a),
    .b_i        (slice_b),
    .cin_i      (carry_q),
    .sum_o      (slice_sum),
    .cout_o     (slice_cout),
    .overflow_o (slice_ovf)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
`ifdef MP_ADD_SUB_EN
    sub_d   = sub_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = RUN;
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = cin_eff;
          idx_d   = '0;
`ifdef MP_ADD_SUB_EN
          sub_d   = bus.sub;
`endif
        end
      end
      RUN: begin
        sum_d[int'(idx_q)*WIDTH +: WIDTH] = slice_sum;
        carry_d = slice_cout;
        if (idx_q == IDX_W'(WORDS - 1)) begin
          state_d = DONE;
          cout_d  = slice_cout;
          ovf_d   = slice_ovf;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef MP_ADD_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
`ifdef MP_ADD_SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end

  // Handshake outputs depend on state only.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_mp_add_sequencer.sv
// tb/tb_mp_add_sequencer.sv - self-checking bench for mp_add_sequencer (WIDTH=8, WORDS=4)
module tb_mp_add_sequencer;
  localparam int W = 8;
  localparam int N = 4;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  mp_add_sequencer_if #(.WIDTH(W), .WORDS(N)) bus ();

  mp_add_sequencer #(.WIDTH(W), .WORDS(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference arithmetic on the full 32-bit operands.
  function automatic void ref_op(input logic [31:0] a, input logic [31:0] b,
                                 input logic ci, input logic sb,
                                 output logic [31:0] s, output logic co, output logic ov);
    longint sa, sbv, r;
    logic [32:0] u;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
`ifdef MP_ADD_SUB_EN
    if (sb) begin
      s  = a - b;
      co = (a >= b);
      r  = sa - sbv;
      ov = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      return;
    end
`endif
    u  = {1'b0, a} + {1'b0, b} + {32'b0, ci};
    s  = u[31:0];
    co = u[32];
    r  = sa + sbv + longint'(ci);
    ov = (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  // Cycle-level model: phase 0 = idle, 1 = computing, 2 = result presented.
  int          ph;
  int          rem;
  logic [31:0] m_sum, p_sum;
  logic        m_cout, m_ovf, p_cout, p_ovf;

  initial begin
    ph = 0; rem = 0;
    m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0;
    p_sum = '0; p_cout = 1'b0; p_ovf = 1'b0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      ph = 0; rem = 0;
      m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0;
    end else begin
      chk("mon_in_ready", bus.in_ready, (ph == 0));
      chk("mon_out_valid", bus.out_valid, (ph == 2));
      if (ph != 1) begin
        chk("mon_sum", bus.sum, m_sum);
        chk("mon_cout", bus.cout, m_cout);
        chk("mon_overflow", bus.overflow, m_ovf);
      end
      if (ph == 0) begin
        if (bus.in_valid) begin
          ref_op(bus.a, bus.b, bus.cin, bus.sub, p_sum, p_cout, p_ovf);
          ph = 1; rem = N;
        end
      end else if (ph == 1) begin
        rem--;
        if (rem == 0) begin
          ph = 2; m_sum = p_sum; m_cout = p_cout; m_ovf = p_ovf;
        end
      end else if (bus.out_ready) begin
        ph = 0;
      end
    end
  end

  task automatic do_op(input logic [31:0] ta, input logic [31:0] tb, input logic tcin,
                       input logic tsub, input int hold, input bit early, input bit pulse,
                       output logic [31:0] rs, output logic rc, output logic ro, output int lat);
    int guard;
    guard = 0;
    while (!bus.in_ready && guard < 20) begin
      @(posedge clk); #1; guard++;
    end
    if (!bus.in_ready) chk("in_ready_wait", bus.in_ready, 1'b1);
    bus.in_valid = 1'b1; bus.a = ta; bus.b = tb; bus.cin = tcin; bus.sub = tsub;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a = $urandom; bus.b = $urandom; bus.cin = 1'($urandom); bus.sub = 1'($urandom);
    if (early) bus.out_ready = 1'b1;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      bus.in_valid = (pulse && lat == 1);
      if (pulse && lat == 1) begin bus.a = $urandom; bus.b = $urandom; end
      @(posedge clk); #1; lat++;
    end
    bus.in_valid = 1'b0;
    if (!bus.out_valid) chk("out_valid_wait", bus.out_valid, 1'b1);
    rs = bus.sum; rc = bus.cout; ro = bus.overflow;
    if (!early) begin
      repeat (hold) begin
        @(posedge clk); #1;
        chk("bp_in_ready", bus.in_ready, 1'b0);
        chk("bp_out_valid", bus.out_valid, 1'b1);
        chk("bp_sum_stable", bus.sum, rs);
      end
      bus.out_ready = 1'b1;
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("handoff_in_ready", bus.in_ready, 1'b1);
  endtask

  task automatic directed(input string name, input logic [31:0] ta, input logic [31:0] tb,
                          input logic tcin, input logic tsub,
                          input logic [31:0] es, input logic ec, input logic eo);
    logic [31:0] rs; logic rc, ro; int lat;
    do_op(ta, tb, tcin, tsub, 0, 1'b0, 1'b0, rs, rc, ro, lat);
    chk({name, "_sum"}, rs, es);
    chk({name, "_cout"}, rc, ec);
    chk({name, "_ovf"}, ro, eo);
    chk({name, "_latency"}, lat, N);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'hFFFF_FFFF;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h0000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] rs; logic rc, ro; int lat;
    n_pass = 0; n_total = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_sum", bus.sum, 32'h0);
    chk("rst_cout", bus.cout, 1'b0);
    chk("rst_overflow", bus.overflow, 1'b0);
    #11 rst_n = 1'b1;
    @(posedge clk); #1;

    directed("carry_chain", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
    directed("full_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    directed("wrap_cin", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    directed("signed_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
`ifdef MP_ADD_SUB_EN
    directed("sub_borrow", 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    directed("sub_pos", 32'd7, 32'd5, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
`else
    directed("sub_ignored", 32'd5, 32'd7, 1'b0, 1'b1, 32'h0000_000C, 1'b0, 1'b0);
`endif

    // Backpressure plus an in_valid pulse during RUN.
    do_op(32'h1234_5678, 32'h0F0F_0F0F, 1'b1, 1'b0, 3, 1'b0, 1'b1, rs, rc, ro, lat);
    chk("bp_sum", rs, 32'h2143_6588);
    // out_ready already high when DONE is entered.
    do_op(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, 0, 1'b1, 1'b0, rs, rc, ro, lat);
    chk("early_sum", rs, 32'h0000_0030);

    // Reset in the middle of RUN.
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.a = 32'hDEAD_BEEF; bus.b = 32'h1111_1111; bus.cin = 1'b0; bus.sub = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", bus.out_valid, 1'b0);
    chk("midrst_in_ready", bus.in_ready, 1'b1);
    chk("midrst_sum", bus.sum, 32'h0);
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    directed("after_rst", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      do_op(pick(), pick(), 1'($urandom), 1'($urandom), $urandom_range(0, 3),
            1'($urandom_range(0, 3) == 0), 1'($urandom), rs, rc, ro, lat);
      chk("rand_latency", lat, N);
    end

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
    $fatal(1, "watchdog");
  end
endmodule
